data_stack: RTL and testbench
=============================

DATA_STACK -- requirements
Module: data_stack

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data word width (matches ALU operand width).
REQ-002 SHALL have parameter: DEPTH, 16, entries; power of two, >=4.
REQ-003 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: op_valid  input  1  op is executed on this edge when high.
REQ-006 SHALL have port: op  input  3  0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 REPL1, 6 REPL2, 7 reserved.
REQ-007 SHALL have port: din  input  WIDTH  value for PUSH/REPL1/REPL2 (REPLx carries the ALU result q).
REQ-008 SHALL have port: tos  output  WIDTH  top of stack; feeds ALU operand a.
REQ-009 SHALL have port: nos  output  WIDTH  next of stack; feeds ALU operand b.
REQ-010 SHALL have port: depth  output  $clog2(DEPTH)+1  current entry count.
REQ-011 SHALL have port: empty  output  1  depth==0.
REQ-012 SHALL have port: full  output  1  depth==DEPTH.
REQ-013 SHALL have port: ovf  output  1  sticky overflow error.
REQ-014 SHALL have port: unf  output  1  sticky underflow error.

Function
REQ-015 SHALL hold state unchanged when op_valid=0 or op=NOP or op=7.
REQ-016 SHALL apply each op on the clk edge it is sampled; tos/nos/depth/empty/full reflect it one cycle later, no extra latency.
REQ-017 SHALL drive tos, nos, empty, full combinationally from registered state (no read latency).
REQ-018 SHALL drive tos=0 when depth<1 and nos=0 when depth<2.
REQ-019 PUSH: din becomes tos, old tos becomes nos, depth+1; requires depth<DEPTH.
REQ-020 POP: remove tos, depth-1; requires depth>=1.
REQ-021 DUP: push copy of tos, depth+1; requires 1<=depth<DEPTH.
REQ-022 SWAP: exchange tos and nos, depth unchanged; requires depth>=2.
REQ-023 REPL1 (unary ALU result): tos<=din, depth unchanged; requires depth>=1.
REQ-024 REPL2 (binary ALU result): remove tos and nos, push din, depth-1; requires depth>=2.
REQ-025 SHALL treat an op as overflowing if it would make depth>DEPTH, underflowing if it needs more entries than present.
REQ-026 SHALL leave entries below those touched by an op bit-exact.
REQ-027 SHALL not alter state on an illegal op (see Configuration for flags).

Reset
REQ-028 SHALL, on rising edge with rst_n=0, set depth=0, empty=1, full=0, tos=0, nos=0, ovf=0, unf=0; storage contents need not be cleared.
REQ-029 SHALL let reset override any concurrent op_valid; the op is discarded.
REQ-030 SHALL have ovf/unf cleared only by reset.

Configuration
REQ-031 Macro DATA_STACK_GUARD_EN defined: illegal ops (REQ-025) SHALL leave state unchanged and set ovf or unf on the same edge; both stay set until reset.
REQ-032 Macro DATA_STACK_GUARD_EN undefined: ovf and unf SHALL be tied 0; illegal ops SHALL be executed with storage addressing modulo DEPTH and depth saturating at 0 and DEPTH (no wrap of depth).

Verification
REQ-033 Reset then PUSH 0x12, PUSH 0x34 -> tos=0x34, nos=0x12, depth=2, empty=0.
REQ-034 With 0x12,0x34 on stack: REPL2 din=0x46 -> tos=0x46, nos=0, depth=1; then REPL1 din=0xB9 -> tos=0xB9, depth=1.
REQ-035 PUSH 0x01..0x10 (16 pushes) -> full=1, depth=16, tos=0x10; 17th PUSH 0xFF (guard on) -> ovf=1, tos=0x10, depth=16.
REQ-036 From empty: POP (guard on) -> unf=1, depth=0, tos=0; then PUSH 0x55 -> tos=0x55, unf still 1.
REQ-037 Stack 0xAA,0xBB (tos 0xBB): SWAP -> tos=0xAA, nos=0xBB; DUP -> tos=0xAA, nos=0xAA, depth=3.
REQ-038 op_valid=1 PUSH 0x77 with rst_n=0 on same edge -> depth=0, tos=0, ovf=unf=0 next cycle.

Source files
------------

// File: rtl/data_stack.sv
// Register-file operand stack feeding the ALU: tos/nos exposed combinationally.
// Define DATA_STACK_GUARD_EN to block illegal ops and raise sticky ovf/unf.
module data_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     op_valid,
    input  logic [2:0]               op,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         tos,
    output logic [WIDTH-1:0]         nos,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     empty,
    output logic                     full,
    output logic                     ovf,
    output logic                     unf
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_DUP   = 3'd3;
    localparam logic [2:0] OP_SWAP  = 3'd4;
    localparam logic [2:0] OP_REPL1 = 3'd5;
    localparam logic [2:0] OP_REPL2 = 3'd6;

    localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DW-1:0]    r_depth;

    logic [AW-1:0]    w_free;
    logic [AW-1:0]    w_top;
    logic [AW-1:0]    w_sec;
    logic [WIDTH-1:0] w_mtop;
    logic [WIDTH-1:0] w_msec;
    logic             w_full;
    logic             w_lt1;
    logic             w_lt2;
    logic [DW-1:0]    w_inc;
    logic [DW-1:0]    w_dec;

    logic             w_push;
    logic             w_pop;
    logic             w_dup;
    logic             w_swap;
    logic             w_repl1;
    logic             w_repl2;

    logic             w_we0;
    logic [AW-1:0]    w_idx0;
    logic [WIDTH-1:0] w_dat0;
    logic             w_we1;
    logic [AW-1:0]    w_idx1;
    logic [WIDTH-1:0] w_dat1;
    logic [DW-1:0]    w_dnxt;
    logic             w_ok;

    // Slot indices wrap modulo DEPTH so an unguarded build stays in range.
    assign w_free = r_depth[AW-1:0];
    assign w_top  = w_free - AW'(1);
    assign w_sec  = w_free - AW'(2);
    assign w_mtop = r_mem[w_top];
    assign w_msec = r_mem[w_sec];

    assign w_full = (r_depth == FULL_CNT);
    assign w_lt1  = (r_depth == '0);
    assign w_lt2  = (r_depth < DW'(2));
    assign w_inc  = w_full ? r_depth : r_depth + DW'(1);
    assign w_dec  = w_lt1 ? r_depth : r_depth - DW'(1);

    assign w_push  = op_valid && (op == OP_PUSH);
    assign w_pop   = op_valid && (op == OP_POP);
    assign w_dup   = op_valid && (op == OP_DUP);
    assign w_swap  = op_valid && (op == OP_SWAP);
    assign w_repl1 = op_valid && (op == OP_REPL1);
    assign w_repl2 = op_valid && (op == OP_REPL2);

    always_comb begin
        w_we0  = 1'b0;
        w_idx0 = w_top;
        w_dat0 = din;
        w_we1  = 1'b0;
        w_idx1 = w_sec;
        w_dat1 = w_mtop;
        w_dnxt = r_depth;
        unique case (1'b1)
            w_push: begin
                w_we0  = 1'b1;
                w_idx0 = w_free;
                w_dnxt = w_inc;
            end
            w_pop: begin
                w_dnxt = w_dec;
            end
            w_dup: begin
                w_we0  = 1'b1;
                w_idx0 = w_free;
                w_dat0 = w_mtop;
                w_dnxt = w_inc;
            end
            w_swap: begin
                w_we0  = 1'b1;
                w_dat0 = w_msec;
                w_we1  = 1'b1;
            end
            w_repl1: begin
                w_we0  = 1'b1;
            end
            w_repl2: begin
                w_we0  = 1'b1;
                w_idx0 = w_sec;
                w_dnxt = w_dec;
            end
            default: ;
        endcase
    end

`ifdef DATA_STACK_GUARD_EN
    logic w_err_o;
    logic w_err_u;
    logic r_ovf;
    logic r_unf;

    assign w_err_o = (w_push || w_dup) && w_full;
    assign w_err_u = ((w_pop || w_dup || w_repl1) && w_lt1)
                   || ((w_swap || w_repl2) && w_lt2);
    assign w_ok    = !(w_err_o || w_err_u);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_err_o) r_ovf <= 1'b1;
            if (w_err_u) r_unf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
    assign unf = r_unf;
`else
    assign w_ok = 1'b1;
    assign ovf  = 1'b0;
    assign unf  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_depth <= '0;
        end else if (w_ok) begin
            r_depth <= w_dnxt;
        end
    end

    // Storage is never cleared; the depth count alone defines validity.
    always_ff @(posedge clk) begin
        if (rst_n && w_ok) begin
            if (w_we0) r_mem[w_idx0] <= w_dat0;
            if (w_we1) r_mem[w_idx1] <= w_dat1;
        end
    end

    assign tos   = w_lt1 ? '0 : w_mtop;
    assign nos   = w_lt2 ? '0 : w_msec;
    assign depth = r_depth;
    assign empty = w_lt1;
    assign full  = w_full;

endmodule

// File: tb/tb_data_stack.sv
// Scoreboard bench for data_stack: stimulus queues expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_data_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

`ifdef DATA_STACK_GUARD_EN
    localparam logic G = 1'b1;
`else
    localparam logic G = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [4:0]       depth;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op       (op),
        .din      (din),
        .tos      (tos),
        .nos      (nos),
        .depth    (depth),
        .empty    (empty),
        .full     (full),
        .ovf      (ovf),
        .unf      (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] tos;
        logic [7:0] nos;
        logic [4:0] depth;
        logic       empty;
        logic       full;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input string fld,
                       input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "tos",   tos,           e.tos);
            chk(e.name, "nos",   nos,           e.nos);
            chk(e.name, "depth", {3'b0, depth}, {3'b0, e.depth});
            chk(e.name, "empty", {7'b0, empty}, {7'b0, e.empty});
            chk(e.name, "full",  {7'b0, full},  {7'b0, e.full});
            chk(e.name, "ovf",   {7'b0, ovf},   {7'b0, e.ovf});
            chk(e.name, "unf",   {7'b0, unf},   {7'b0, e.unf});
        end
    end

    task automatic step(input string nm, input logic rn, input logic v,
                        input logic [2:0] o, input logic [7:0] d,
                        input logic [7:0] et, input logic [7:0] en,
                        input logic [4:0] ed, input logic ef,
                        input logic eo, input logic eu);
        exp_t e;
        @(negedge clk);
        rst_n    = rn;
        op_valid = v;
        op       = o;
        din      = d;
        @(posedge clk);
        #1;
        e.name  = nm;
        e.tos   = et;
        e.nos   = en;
        e.depth = ed;
        e.empty = (ed == 5'd0);
        e.full  = ef;
        e.ovf   = eo;
        e.unf   = eu;
        sb.push_back(e);
    endtask

    task automatic rst();
        step("reset", 1'b0, 1'b0, 3'd0, 8'h00,
             8'h00, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int waitc;
        logic [7:0] v;
        rst_n = 1'b0;
        op_valid = 1'b0;
        op = 3'd0;
        din = 8'h00;

        rst();
        step("push12", 1, 1, 3'd1, 8'h12, 8'h12, 8'h00, 5'd1, 0, 0, 0);
        step("push34", 1, 1, 3'd1, 8'h34, 8'h34, 8'h12, 5'd2, 0, 0, 0);
        step("repl2",  1, 1, 3'd6, 8'h46, 8'h46, 8'h00, 5'd1, 0, 0, 0);
        step("repl1",  1, 1, 3'd5, 8'hB9, 8'hB9, 8'h00, 5'd1, 0, 0, 0);
        step("nop",    1, 1, 3'd0, 8'h11, 8'hB9, 8'h00, 5'd1, 0, 0, 0);
        step("op7",    1, 1, 3'd7, 8'h22, 8'hB9, 8'h00, 5'd1, 0, 0, 0);
        step("novld",  1, 0, 3'd1, 8'h33, 8'hB9, 8'h00, 5'd1, 0, 0, 0);
        step("pop1",   1, 1, 3'd2, 8'h00, 8'h00, 8'h00, 5'd0, 0, 0, 0);

        rst();
        for (int i = 1; i <= 16; i++) begin
            v = 8'(i);
            step($sformatf("fill%0d", i), 1, 1, 3'd1, v,
                 v, v - 8'h01, 5'(i), (i == 16), 0, 0);
        end
        step("push17", 1, 1, 3'd1, 8'hFF, 8'h10, 8'h0F, 5'd16, 1, G, 0);
        step("popfull", 1, 1, 3'd2, 8'h00, 8'h0F, 8'h0E, 5'd15, 0, G, 0);

        rst();
        step("popempty", 1, 1, 3'd2, 8'h00, 8'h00, 8'h00, 5'd0, 0, 0, G);
        step("push55",   1, 1, 3'd1, 8'h55, 8'h55, 8'h00, 5'd1, 0, 0, G);

        rst();
        step("pushAA", 1, 1, 3'd1, 8'hAA, 8'hAA, 8'h00, 5'd1, 0, 0, 0);
        step("pushBB", 1, 1, 3'd1, 8'hBB, 8'hBB, 8'hAA, 5'd2, 0, 0, 0);
        step("swap",   1, 1, 3'd4, 8'h00, 8'hAA, 8'hBB, 5'd2, 0, 0, 0);
        step("dup",    1, 1, 3'd3, 8'h00, 8'hAA, 8'hAA, 5'd3, 0, 0, 0);
        step("popdup", 1, 1, 3'd2, 8'h00, 8'hAA, 8'hBB, 5'd2, 0, 0, 0);
        step("repl2b", 1, 1, 3'd6, 8'h65, 8'h65, 8'h00, 5'd1, 0, 0, 0);
        step("pop2",   1, 1, 3'd2, 8'h00, 8'h00, 8'h00, 5'd0, 0, 0, 0);
        step("pop3",   1, 1, 3'd2, 8'h00, 8'h00, 8'h00, 5'd0, 0, 0, G);
        step("rstpush", 0, 1, 3'd1, 8'h77, 8'h00, 8'h00, 5'd0, 0, 0, 0);
        step("idle",    1, 0, 3'd0, 8'h00, 8'h00, 8'h00, 5'd0, 0, 0, 0);

        waitc = 0;
        while (sb.size() > 0 && waitc < 10) begin
            @(posedge clk);
            waitc++;
        end
        n_chk++;
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
